change_dispenser: RTL
=====================

# change_dispenser

Downstream stage of the candy vending FSM. Takes the change amount computed when a purchase completes and pays it out as a timed sequence of single-coin eject pulses (quarter, dime, nickel) to the coin-ejector mechanism. Tracks per-denomination coin inventory and flags when exact change cannot be paid.

## Interface
Parameters:
- WIDTH, 32, width of amount/remaining (matches the upstream `change` output)
- INV_W, 8, width of each inventory counter
- GAP, 4, idle cycles required by the ejector after each eject pulse (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  one-cycle start strobe; accepted only in IDLE
- amount  in  WIDTH  change in cents, sampled on the accepted req cycle
- refill  in  1  inventory load strobe; accepted only in IDLE
- refill_sel  in  2  0 = nickel, 1 = dime, 2 = quarter, 3 = ignored
- refill_cnt  in  INV_W  count added to the selected inventory (saturating)
- eject_25 / eject_10 / eject_5  out  1 each  one-cycle eject pulse; at most one high per cycle
- busy  out  1  high from the cycle after an accepted req until done
- done  out  1  one-cycle completion pulse
- short  out  1  valid with done; held until next accepted req; 1 = remaining ≠ 0 at completion
- remaining  out  WIDTH  cents still owed; registered
- inv_25 / inv_10 / inv_5  out  INV_W each  current inventory

## Operation
- Reset: state IDLE. All eject_*, busy, done, short = 0. remaining = 0. All inventories = 0.
- States: IDLE, SELECT, EJECT, WAIT, DONE.
- IDLE: on req, load remaining ← amount, clear short, go to SELECT.
- SELECT: greedy choice, evaluated in this order:
  - remaining ≥ 25 and inv_25 > 0 → quarter
  - else remaining ≥ 10 and inv_10 > 0 → dime
  - else remaining ≥ 5 and inv_5 > 0 → nickel
  - else → DONE
  - If a coin is chosen, go to EJECT.
- EJECT (1 cycle): the chosen eject_* is high. In the same edge, remaining −= coin value and the matching inventory −= 1. Go to WAIT.
- WAIT: count GAP cycles, then go to SELECT.
- DONE (1 cycle): done = 1, short = (remaining ≠ 0), then go to IDLE. remaining holds its value until the next req.
- Greedy is the decided algorithm. No backtracking: with no nickels, 30 pays as 25 and then ends short with remaining = 5.
- Amounts that are not a multiple of 5 end short with the residual in remaining (1–4).
- req while not in IDLE is ignored (no queueing).
- refill while not in IDLE is ignored.
- refill_sel = 3 has no effect.
- Inventory adds saturate at 2^INV_W − 1.
- req and refill in the same IDLE cycle: both are honoured. SELECT sees the refilled inventory.
- Arithmetic is unsigned. remaining never underflows because a coin is only chosen when remaining ≥ its value.

## Timing
- Accepted req at cycle 0: SELECT at cycle 1.
  - First eject pulse at cycle 2, or done at cycle 2 if no coin is possible (including amount = 0).
- Coin period: GAP + 2 cycles. Eject at cycle c means WAIT occupies c+1 … c+GAP, SELECT at c+GAP+1, next eject at c+GAP+2.
- After the last eject at cycle c: done at cycle c+GAP+2.
- busy is high from cycle 1 through the done cycle. It is low in the cycle after done.
- A new req is accepted the cycle after done.
- rst mid-payout: on the next edge, everything returns to reset values, including inventories. No pulse is emitted after the reset edge.

## Structure
- Shared package `candy_pkg`:
  - state enum for this block
  - coin value constants: NICKEL = 5, DIME = 10, QUARTER = 25
  - refill_sel encoding
- Sub-module `coin_inventory`: three INV_W counters with a saturating refill add and a single-denomination decrement. Outputs inv_* and a nonzero flag per denomination.
- Top level holds the FSM, the GAP counter and the remaining register.

## Test plan
- Refill 10 of each, req amount = 40, GAP = 4 → eject_25 @2, eject_10 @8, eject_5 @14; done @20, short = 0, remaining = 0; inventories 9/9/9.
- Refill only dimes = 5, req amount = 30 → eject_10 @2, @8, @14; done @20, short = 0, inv_10 = 2.
- Refill quarters = 1, dimes = 1, no nickels, req amount = 30 → eject_25 @2; done @8, short = 1, remaining = 5.
- req amount = 0 → no eject; done @2, short = 0. req amount = 7 with full inventory → one nickel; done with short = 1, remaining = 2.
- req during busy and refill during busy → ignored: payout sequence and inventories unchanged. refill_cnt = 255 on inv = 10 → saturates to 255.
- rst asserted one cycle after the first eject of amount = 40 → all outputs and inventories 0 on the next edge; no further eject pulses.

Source files
------------

// File: rtl/candy_pkg.sv
// Shared types and constants for the candy vending datapath.
// Holds the change dispenser state encoding, coin values and refill selector.
package candy_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } disp_state_t;

    localparam int unsigned NICKEL  = 5;
    localparam int unsigned DIME    = 10;
    localparam int unsigned QUARTER = 25;
    localparam int unsigned COIN_W  = 5;

    // Doubles as the refill_sel encoding and the chosen-coin tag.
    typedef enum logic [1:0] {
        SEL_NICKEL  = 2'd0,
        SEL_DIME    = 2'd1,
        SEL_QUARTER = 2'd2,
        SEL_NONE    = 2'd3
    } coin_sel_t;

    function automatic logic [COIN_W-1:0] coin_value(input coin_sel_t sel);
        logic [COIN_W-1:0] v;
        case (sel)
            SEL_QUARTER: v = COIN_W'(QUARTER);
            SEL_DIME:    v = COIN_W'(DIME);
            SEL_NICKEL:  v = COIN_W'(NICKEL);
            default:     v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/refill inputs and eject/status outputs of the change dispenser.
interface change_dispenser_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INV_W = 8
);
    logic             req;
    logic [WIDTH-1:0] amount;
    logic             refill;
    logic [1:0]       refill_sel;
    logic [INV_W-1:0] refill_cnt;
    logic             eject_25;
    logic             eject_10;
    logic             eject_5;
    logic             busy;
    logic             done;
    logic             short;
    logic [WIDTH-1:0] remaining;
    logic [INV_W-1:0] inv_25;
    logic [INV_W-1:0] inv_10;
    logic [INV_W-1:0] inv_5;

    modport master (
        output req, amount, refill, refill_sel, refill_cnt,
        input  eject_25, eject_10, eject_5, busy, done, short, remaining,
               inv_25, inv_10, inv_5
    );

    modport slave (
        input  req, amount, refill, refill_sel, refill_cnt,
        output eject_25, eject_10, eject_5, busy, done, short, remaining,
               inv_25, inv_10, inv_5
    );
endinterface

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: saturating refill add, single-coin decrement.
module coin_inventory
    import candy_pkg::*;
#(
    parameter int unsigned INV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_refill,
    input  coin_sel_t        i_refill_sel,
    input  logic [INV_W-1:0] i_refill_cnt,
    input  logic             i_dec,
    input  coin_sel_t        i_dec_sel,
    output logic [INV_W-1:0] o_inv_25,
    output logic [INV_W-1:0] o_inv_10,
    output logic [INV_W-1:0] o_inv_5,
    output logic             o_nz_25_c,
    output logic             o_nz_10_c,
    output logic             o_nz_5_c
);

    logic [INV_W-1:0] r_inv_25;
    logic [INV_W-1:0] r_inv_10;
    logic [INV_W-1:0] r_inv_5;

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                 input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? '1 : s[INV_W-1:0];
    endfunction

    // Refill and decrement never coincide: refill is IDLE-only, decrement EJECT-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_25 <= '0;
            r_inv_10 <= '0;
            r_inv_5  <= '0;
        end else if (i_refill) begin
            case (i_refill_sel)
                SEL_QUARTER: r_inv_25 <= sat_add(r_inv_25, i_refill_cnt);
                SEL_DIME:    r_inv_10 <= sat_add(r_inv_10, i_refill_cnt);
                SEL_NICKEL:  r_inv_5  <= sat_add(r_inv_5, i_refill_cnt);
                default:     ;
            endcase
        end else if (i_dec) begin
            case (i_dec_sel)
                SEL_QUARTER: r_inv_25 <= r_inv_25 - INV_W'(1);
                SEL_DIME:    r_inv_10 <= r_inv_10 - INV_W'(1);
                SEL_NICKEL:  r_inv_5  <= r_inv_5 - INV_W'(1);
                default:     ;
            endcase
        end
    end

    assign o_inv_25  = r_inv_25;
    assign o_inv_10  = r_inv_10;
    assign o_inv_5   = r_inv_5;
    assign o_nz_25_c = |r_inv_25;
    assign o_nz_10_c = |r_inv_10;
    assign o_nz_5_c  = |r_inv_5;

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount as greedy quarter/dime/nickel eject pulses,
// spaced by GAP idle cycles, and reports any amount it could not pay.
module change_dispenser
    import candy_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INV_W = 8,
    parameter int unsigned GAP   = 4
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    disp_state_t      r_state;
    disp_state_t      w_next_state;
    coin_sel_t        r_coin;
    coin_sel_t        w_pick;
    logic             w_accept;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [WIDTH-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;
    logic             r_short;
    logic             r_eject_25;
    logic             r_eject_10;
    logic             r_eject_5;
    logic             w_refill;
    logic             w_dec;
    logic             w_nz_25;
    logic             w_nz_10;
    logic             w_nz_5;
    logic [INV_W-1:0] w_inv_25;
    logic [INV_W-1:0] w_inv_10;
    logic [INV_W-1:0] w_inv_5;

    assign w_refill = bus.refill && (r_state == S_IDLE);
    assign w_dec    = (r_state == S_EJECT);

    coin_inventory #(.INV_W(INV_W)) u_inv (
        .clk          (clk),
        .rst          (rst),
        .i_refill     (w_refill),
        .i_refill_sel (coin_sel_t'(bus.refill_sel)),
        .i_refill_cnt (bus.refill_cnt),
        .i_dec        (w_dec),
        .i_dec_sel    (r_coin),
        .o_inv_25     (w_inv_25),
        .o_inv_10     (w_inv_10),
        .o_inv_5      (w_inv_5),
        .o_nz_25_c    (w_nz_25),
        .o_nz_10_c    (w_nz_10),
        .o_nz_5_c     (w_nz_5)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and greedy coin choice.
    always_comb begin
        w_next_state = r_state;
        w_pick       = SEL_NONE;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_remaining >= WIDTH'(QUARTER) && w_nz_25)   w_pick = SEL_QUARTER;
                else if (r_remaining >= WIDTH'(DIME) && w_nz_10) w_pick = SEL_DIME;
                else if (r_remaining >= WIDTH'(NICKEL) && w_nz_5) w_pick = SEL_NICKEL;
                w_next_state = (w_pick == SEL_NONE) ? S_DONE : S_EJECT;
            end
            S_EJECT: w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_gap_cnt == GAP_W'(GAP - 1)) w_next_state = S_SELECT;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coin      <= SEL_NONE;
            r_gap_cnt   <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_eject_25  <= 1'b0;
            r_eject_10  <= 1'b0;
            r_eject_5   <= 1'b0;
        end else begin
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            r_eject_25 <= (w_pick == SEL_QUARTER);
            r_eject_10 <= (w_pick == SEL_DIME);
            r_eject_5  <= (w_pick == SEL_NICKEL);
            r_gap_cnt  <= (r_state == S_WAIT) ? r_gap_cnt + GAP_W'(1) : '0;
            if (w_pick != SEL_NONE) r_coin <= w_pick;
            if (w_accept) begin
                r_remaining <= bus.amount;
                r_short     <= 1'b0;
            end else if (r_state == S_EJECT) begin
                r_remaining <= r_remaining - WIDTH'(coin_value(r_coin));
            end
            if (r_state == S_SELECT && w_next_state == S_DONE)
                r_short <= (r_remaining != '0);
        end
    end

    assign bus.eject_25  = r_eject_25;
    assign bus.eject_10  = r_eject_10;
    assign bus.eject_5   = r_eject_5;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.short     = r_short;
    assign bus.remaining = r_remaining;
    assign bus.inv_25    = w_inv_25;
    assign bus.inv_10    = w_inv_10;
    assign bus.inv_5     = w_inv_5;

endmodule
